// File: rtl/hazard_pkg.sv
// rtl/hazard_pkg.sv - shared types for the hazard/forwarding controller
package hazard_pkg;

  typedef enum logic [1:0] {
    FWD_REG = 2'b00,
    FWD_WB  = 2'b01,
    FWD_MEM = 2'b10
  } fwd_sel_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    BUSY = 2'b01,
    DONE = 2'b10
  } muldiv_state_e;

endpackage

// File: rtl/fwd_port_sel.sv
// rtl/fwd_port_sel.sv - forwarding source select for one EX read port
module fwd_port_sel
  import hazard_pkg::*;
#(
  parameter int REG_ADDR_W = 5
) (
  input  logic [REG_ADDR_W-1:0] i_ex_rs,
  input  logic                  i_regWrite_EXtoMEM,
  input  logic [REG_ADDR_W-1:0] i_writeReg_EXtoMEM,
  input  logic                  i_regWrite_MEMtoWB,
  input  logic [REG_ADDR_W-1:0] i_writeReg_MEMtoWB,
  output fwd_sel_e              o_sel
);

  logic w_hit_mem;
  logic w_hit_wb;

  // x0 is hardwired to zero, so a write to it must never be forwarded
  assign w_hit_mem = i_regWrite_EXtoMEM && (i_writeReg_EXtoMEM != '0) &&
                     (i_writeReg_EXtoMEM == i_ex_rs);
  assign w_hit_wb  = i_regWrite_MEMtoWB && (i_writeReg_MEMtoWB != '0) &&
                     (i_writeReg_MEMtoWB == i_ex_rs);

  always_comb begin
    o_sel = FWD_REG;
    if (w_hit_mem) begin
      o_sel = FWD_MEM;
    end else if (w_hit_wb) begin
      o_sel = FWD_WB;
    end
  end

endmodule

// File: rtl/hazard_forward_unit.sv
// rtl/hazard_forward_unit.sv - forwarding, load-use, MUL/DIV hold, branch flush and stall counter
module hazard_forward_unit
  import hazard_pkg::*;
#(
  parameter int NUM_RD_PORTS = 2,
  parameter int REG_ADDR_W   = 5,
  parameter int MULDIV_LAT   = 4,
  parameter int STALL_CNT_W  = 16
) (
  input  logic                               i_clk,
  input  logic                               i_rst_n,
  input  logic [NUM_RD_PORTS*REG_ADDR_W-1:0] i_id_rs,
  input  logic [NUM_RD_PORTS-1:0]            i_id_rs_used,
  input  logic [NUM_RD_PORTS*REG_ADDR_W-1:0] i_ex_rs,
  input  logic [REG_ADDR_W-1:0]              i_ex_rd,
  input  logic                               i_ex_mem_read,
  input  logic                               i_ex_muldiv_start,
  input  logic                               i_branch_taken_ex,
  input  logic                               i_regWrite_EXtoMEM,
  input  logic [REG_ADDR_W-1:0]              i_writeReg_EXtoMEM,
  input  logic                               i_regWrite_MEMtoWB,
  input  logic [REG_ADDR_W-1:0]              i_writeReg_MEMtoWB,
  output logic [2*NUM_RD_PORTS-1:0]          o_forward_sel,
  output logic                               o_stall_if,
  output logic                               o_stall_id,
  output logic                               o_stall_ex,
  output logic                               o_flush_id,
  output logic                               o_flush_ex,
  output logic                               o_muldiv_done,
  output logic [STALL_CNT_W-1:0]             o_stall_count
);

  localparam int CNT_W = (MULDIV_LAT > 3) ? $clog2(MULDIV_LAT - 2) : 1;
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'((MULDIV_LAT > 2) ? MULDIV_LAT - 3 : 0);

  if (MULDIV_LAT < 2) begin : g_bad_lat
    $error("hazard_forward_unit: MULDIV_LAT must be at least 2");
  end

  muldiv_state_e             r_state;
  logic [CNT_W-1:0]          r_cnt;
  logic [STALL_CNT_W-1:0]    r_stall_cnt;
  logic [NUM_RD_PORTS-1:0]   w_lu_hit;
  logic [2*NUM_RD_PORTS-1:0] w_fwd;
  logic w_load_use;
  logic w_start;
  logic w_stall_if, w_stall_id, w_stall_ex, w_flush_id, w_flush_ex;

  for (genvar k = 0; k < NUM_RD_PORTS; k++) begin : g_port
    fwd_sel_e w_sel;

    fwd_port_sel #(.REG_ADDR_W(REG_ADDR_W)) u_sel (
      .i_ex_rs            (i_ex_rs[k*REG_ADDR_W +: REG_ADDR_W]),
      .i_regWrite_EXtoMEM (i_regWrite_EXtoMEM),
      .i_writeReg_EXtoMEM (i_writeReg_EXtoMEM),
      .i_regWrite_MEMtoWB (i_regWrite_MEMtoWB),
      .i_writeReg_MEMtoWB (i_writeReg_MEMtoWB),
      .o_sel              (w_sel)
    );

    assign w_fwd[2*k +: 2] = w_sel;
    assign w_lu_hit[k]     = i_id_rs_used[k] &&
                             (i_id_rs[k*REG_ADDR_W +: REG_ADDR_W] == i_ex_rd);
  end

  assign w_load_use = i_ex_mem_read && (i_ex_rd != '0) && (|w_lu_hit);
  // A taken branch squashes the MUL/DIV sitting in EX, so it never starts
  assign w_start    = (r_state == IDLE) && i_ex_muldiv_start && !i_branch_taken_ex;

  always_comb begin
    w_stall_if = 1'b0;
    w_stall_id = 1'b0;
    w_stall_ex = 1'b0;
    w_flush_id = 1'b0;
    w_flush_ex = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (i_branch_taken_ex) begin
          w_flush_id = 1'b1;
          w_flush_ex = 1'b1;
        end else if (w_start) begin
          w_stall_if = 1'b1;
          w_stall_id = 1'b1;
          w_stall_ex = 1'b1;
        end else if (w_load_use) begin
          w_stall_if = 1'b1;
          w_stall_id = 1'b1;
          w_flush_ex = 1'b1;
        end
      end
      BUSY: begin
        w_stall_if = 1'b1;
        w_stall_id = 1'b1;
        w_stall_ex = 1'b1;
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= IDLE;
      r_cnt   <= '0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (w_start) begin
            if (MULDIV_LAT == 2) begin
              r_state <= DONE;
            end else begin
              r_state <= BUSY;
              r_cnt   <= CNT_INIT;
            end
          end
        end
        BUSY: begin
          if (r_cnt == '0) begin
            r_state <= DONE;
          end else begin
            r_cnt <= r_cnt - CNT_W'(1);
          end
        end
        DONE:    r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_stall_cnt <= '0;
    end else if (w_stall_if && (r_stall_cnt != '1)) begin
      r_stall_cnt <= r_stall_cnt + STALL_CNT_W'(1);
    end
  end

  // Combinational outputs are gated so everything reads 0 while reset is held
  assign o_forward_sel = {(2*NUM_RD_PORTS){i_rst_n}} & w_fwd;
  assign o_stall_if    = i_rst_n & w_stall_if;
  assign o_stall_id    = i_rst_n & w_stall_id;
  assign o_stall_ex    = i_rst_n & w_stall_ex;
  assign o_flush_id    = i_rst_n & w_flush_id;
  assign o_flush_ex    = i_rst_n & w_flush_ex;
  assign o_muldiv_done = i_rst_n & (r_state == DONE);
  assign o_stall_count = r_stall_cnt;

endmodule

// File: tb/tb_hazard_forward_unit.sv
// tb/tb_hazard_forward_unit.sv - randomized self-checking bench for hazard_forward_unit
module tb_hazard_forward_unit;

  localparam int N   = 2;
  localparam int W   = 5;
  localparam int LAT = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [N*W-1:0] id_rs, ex_rs;
  logic [N-1:0]   id_rs_used;
  logic [W-1:0]   ex_rd, wr_mem, wr_wb;
  logic ex_mem_read, muldiv_start, branch, rw_mem, rw_wb;

  logic [2*N-1:0] fsel, fsel_s;
  logic sif, sid, sex, fid, fex, done;
  logic sif_s, sid_s, sex_s, fid_s, fex_s, done_s;
  logic [15:0] cnt;
  logic [3:0]  cnt_s;

  wire [5:0] ctl   = {sif, sid, sex, fid, fex, done};
  wire [5:0] ctl_s = {sif_s, sid_s, sex_s, fid_s, fex_s, done_s};

  int errors = 0;
  int checks = 0;
  int exp_cnt = 0;

  always #5 clk = ~clk;

  hazard_forward_unit #(.NUM_RD_PORTS(N), .REG_ADDR_W(W), .MULDIV_LAT(LAT), .STALL_CNT_W(16)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_id_rs(id_rs), .i_id_rs_used(id_rs_used), .i_ex_rs(ex_rs),
    .i_ex_rd(ex_rd), .i_ex_mem_read(ex_mem_read), .i_ex_muldiv_start(muldiv_start),
    .i_branch_taken_ex(branch), .i_regWrite_EXtoMEM(rw_mem), .i_writeReg_EXtoMEM(wr_mem),
    .i_regWrite_MEMtoWB(rw_wb), .i_writeReg_MEMtoWB(wr_wb), .o_forward_sel(fsel),
    .o_stall_if(sif), .o_stall_id(sid), .o_stall_ex(sex), .o_flush_id(fid), .o_flush_ex(fex),
    .o_muldiv_done(done), .o_stall_count(cnt)
  );

  hazard_forward_unit #(.NUM_RD_PORTS(N), .REG_ADDR_W(W), .MULDIV_LAT(LAT), .STALL_CNT_W(4)) dut_s (
    .i_clk(clk), .i_rst_n(rst_n), .i_id_rs(id_rs), .i_id_rs_used(id_rs_used), .i_ex_rs(ex_rs),
    .i_ex_rd(ex_rd), .i_ex_mem_read(ex_mem_read), .i_ex_muldiv_start(muldiv_start),
    .i_branch_taken_ex(branch), .i_regWrite_EXtoMEM(rw_mem), .i_writeReg_EXtoMEM(wr_mem),
    .i_regWrite_MEMtoWB(rw_wb), .i_writeReg_MEMtoWB(wr_wb), .o_forward_sel(fsel_s),
    .o_stall_if(sif_s), .o_stall_id(sid_s), .o_stall_ex(sex_s), .o_flush_id(fid_s), .o_flush_ex(fex_s),
    .o_muldiv_done(done_s), .o_stall_count(cnt_s)
  );

  function automatic logic [2*N-1:0] m_fwd();
    logic [2*N-1:0] r;
    int rs;
    for (int k = 0; k < N; k++) begin
      rs = int'(ex_rs[k*W +: W]);
      if (rw_mem && wr_mem != 0 && int'(wr_mem) == rs)     r[2*k +: 2] = 2'b10;
      else if (rw_wb && wr_wb != 0 && int'(wr_wb) == rs)   r[2*k +: 2] = 2'b01;
      else                                                  r[2*k +: 2] = 2'b00;
    end
    return r;
  endfunction

  function automatic bit m_lu();
    bit hit = 0;
    for (int k = 0; k < N; k++)
      if (id_rs_used[k] && id_rs[k*W +: W] == ex_rd) hit = 1;
    return ex_mem_read && ex_rd != 0 && hit;
  endfunction

  function automatic int sat15(int v);
    return (v > 15) ? 15 : v;
  endfunction

  task automatic idle_inputs();
    id_rs = '0; id_rs_used = '0; ex_rs = '0; ex_rd = '0; wr_mem = '0; wr_wb = '0;
    ex_mem_read = 0; muldiv_start = 0; branch = 0; rw_mem = 0; rw_wb = 0;
  endtask

  task automatic adv(input bit exp_sif);
    if (exp_sif) exp_cnt++;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    idle_inputs();
    ex_rs = {5'd3, 5'd3}; rw_mem = 1; wr_mem = 5'd3; muldiv_start = 1;
    ex_mem_read = 1; ex_rd = 5'd3; id_rs = {5'd0, 5'd3}; id_rs_used = 2'b01;
    #2;
    checks++; if (ctl !== 6'b0 || ctl_s !== 6'b0) begin errors++; $display("FAIL reset_ctl got=%b/%b exp=000000", ctl, ctl_s); end
    checks++; if (fsel !== 4'b0 || fsel_s !== 4'b0) begin errors++; $display("FAIL reset_fwd got=%b/%b exp=0000", fsel, fsel_s); end
    checks++; if (cnt !== 16'd0 || cnt_s !== 4'd0) begin errors++; $display("FAIL reset_cnt got=%0d/%0d exp=0", cnt, cnt_s); end
    @(posedge clk); #1;
    idle_inputs();
    rst_n = 1;
    exp_cnt = 0;
  endtask

  task automatic test_forwarding();
    logic [2*N-1:0] ef;
    idle_inputs();
    rw_wb = 1; wr_wb = 5'd5; ex_rs = {5'd7, 5'd5};
    #2;
    checks++; if (fsel !== 4'b0001) begin errors++; $display("FAIL fwd_wb_only got=%b exp=0001", fsel); end
    adv(0);
    rw_mem = 1; wr_mem = 5'd3; rw_wb = 1; wr_wb = 5'd3; ex_rs = {5'd0, 5'd3};
    #2;
    checks++; if (fsel !== 4'b0010) begin errors++; $display("FAIL fwd_mem_prio got=%b exp=0010", fsel); end
    adv(0);
    wr_mem = 5'd0; wr_wb = 5'd0; ex_rs = {5'd0, 5'd0};
    #2;
    checks++; if (fsel !== 4'b0000) begin errors++; $display("FAIL fwd_x0 got=%b exp=0000", fsel); end
    adv(0);
    for (int i = 0; i < 150; i++) begin
      for (int k = 0; k < N; k++) ex_rs[k*W +: W] = W'($urandom_range(0, 3));
      wr_mem = W'($urandom_range(0, 3)); wr_wb = W'($urandom_range(0, 3));
      rw_mem = 1'($urandom); rw_wb = 1'($urandom);
      #2;
      ef = m_fwd();
      checks++;
      if (fsel !== ef || fsel_s !== ef || ctl !== 6'b0) begin
        errors++; $display("FAIL fwd_rand[%0d] got=%b/%b ctl=%b exp=%b ctl=000000", i, fsel, fsel_s, ctl, ef);
      end
      adv(0);
    end
    idle_inputs();
  endtask

  task automatic test_load_use();
    logic [5:0] ec;
    bit lu;
    idle_inputs();
    ex_mem_read = 1; ex_rd = 5'd9; id_rs = {5'd9, 5'd0}; id_rs_used = 2'b10;
    #2;
    checks++; if (ctl !== 6'b110010) begin errors++; $display("FAIL lu_hit got=%b exp=110010", ctl); end
    adv(1);
    ex_mem_read = 0;
    #2;
    checks++; if (ctl !== 6'b0) begin errors++; $display("FAIL lu_bubble got=%b exp=000000", ctl); end
    adv(0);
    ex_mem_read = 1; id_rs_used = 2'b00;
    #2;
    checks++; if (ctl !== 6'b0) begin errors++; $display("FAIL lu_unused got=%b exp=000000", ctl); end
    adv(0);
    for (int i = 0; i < 100; i++) begin
      for (int k = 0; k < N; k++) id_rs[k*W +: W] = W'($urandom_range(0, 3));
      ex_rd = W'($urandom_range(0, 3)); id_rs_used = N'($urandom); ex_mem_read = 1'($urandom);
      #2;
      lu = m_lu();
      ec = lu ? 6'b110010 : 6'b0;
      checks++;
      if (ctl !== ec || cnt !== exp_cnt[15:0] || cnt_s !== 4'(sat15(exp_cnt))) begin
        errors++; $display("FAIL lu_rand[%0d] got=%b cnt=%0d/%0d exp=%b cnt=%0d/%0d", i, ctl, cnt, cnt_s, ec, exp_cnt, sat15(exp_cnt));
      end
      adv(lu);
    end
    idle_inputs();
  endtask

  task automatic test_muldiv();
    logic [5:0] ec;
    bit st;
    int cnt0;
    idle_inputs();
    #2;
    cnt0 = exp_cnt;
    for (int c = 0; c <= LAT; c++) begin
      idle_inputs();
      muldiv_start = (c == 0) || (c == LAT - 1);
      branch = (c == 1);
      if (c == 2) begin ex_mem_read = 1; ex_rd = 5'd9; id_rs = {5'd0, 5'd9}; id_rs_used = 2'b01; end
      #2;
      st = (c < LAT - 1);
      ec = {st, st, st, 1'b0, 1'b0, (c == LAT - 1)};
      checks++;
      if (ctl !== ec) begin errors++; $display("FAIL muldiv_c%0d got=%b exp=%b", c, ctl, ec); end
      adv(st);
    end
    idle_inputs();
    #2;
    checks++;
    if (int'(cnt) - cnt0 !== LAT - 1) begin errors++; $display("FAIL muldiv_cnt got=%0d exp=%0d", int'(cnt) - cnt0, LAT - 1); end
  endtask

  task automatic test_branch_and_reset();
    idle_inputs();
    branch = 1; ex_mem_read = 1; ex_rd = 5'd4; id_rs = {5'd4, 5'd0}; id_rs_used = 2'b10;
    #2;
    checks++; if (ctl !== 6'b000110) begin errors++; $display("FAIL br_lu got=%b exp=000110", ctl); end
    adv(0);
    idle_inputs();
    branch = 1; muldiv_start = 1;
    #2;
    checks++; if (ctl !== 6'b000110) begin errors++; $display("FAIL br_muldiv got=%b exp=000110", ctl); end
    adv(0);
    idle_inputs();
    #2;
    checks++; if (ctl !== 6'b0) begin errors++; $display("FAIL br_stay_idle got=%b exp=000000", ctl); end
    adv(0);
    muldiv_start = 1;
    #2;
    adv(1);
    idle_inputs();
    rw_mem = 1; wr_mem = 5'd6; ex_rs = {5'd6, 5'd6};
    ex_mem_read = 1; ex_rd = 5'd2; id_rs = {5'd2, 5'd2}; id_rs_used = 2'b11;
    #2;
    checks++; if (ctl !== 6'b111000) begin errors++; $display("FAIL busy_stall got=%b exp=111000", ctl); end
    rst_n = 0;
    exp_cnt = 0;
    #1;
    checks++;
    if (ctl !== 6'b0 || fsel !== 4'b0 || cnt !== 16'd0) begin
      errors++; $display("FAIL busy_reset got=%b fwd=%b cnt=%0d exp=000000 fwd=0000 cnt=0", ctl, fsel, cnt);
    end
    @(posedge clk); #1;
    rst_n = 1;
    idle_inputs();
    for (int c = 0; c <= LAT; c++) begin
      #2;
      checks++; if (ctl !== 6'b0) begin errors++; $display("FAIL post_reset_c%0d got=%b exp=000000", c, ctl); end
      adv(0);
    end
  endtask

  task automatic test_saturation();
    idle_inputs();
    ex_mem_read = 1; ex_rd = 5'd11; id_rs = {5'd0, 5'd11}; id_rs_used = 2'b01;
    for (int i = 0; i < 20; i++) begin
      #2;
      checks++;
      if (ctl_s !== 6'b110010 || cnt_s !== 4'(sat15(exp_cnt))) begin
        errors++; $display("FAIL sat_c%0d got=%b cnt=%0d exp=110010 cnt=%0d", i, ctl_s, cnt_s, sat15(exp_cnt));
      end
      adv(1);
    end
    idle_inputs();
    #2;
    checks++;
    if (cnt_s !== 4'd15 || cnt !== exp_cnt[15:0]) begin
      errors++; $display("FAIL sat_final got=%0d/%0d exp=15/%0d", cnt_s, cnt, exp_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_forwarding();
    test_load_use();
    test_muldiv();
    test_branch_and_reset();
    test_saturation();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/hazard_forward_unit.md
Name: hazard_forward_unit

Overview:
Parametrised hazard controller for the 5-stage RISC-V pipeline. It supersedes the plain forwarding logic.
- Generates per-read-port forward selects for EX operands.
- Detects load-use hazards and inserts a one-cycle bubble.
- Holds the pipeline for multi-cycle MUL/DIV ops through a small FSM.
- Issues flushes on a taken branch or jump resolved in EX.
- Keeps a saturating stall-cycle counter for performance analysis.

Parameters:
- NUM_RD_PORTS, 2: number of register read ports tracked (EX operands and ID sources).
- REG_ADDR_W, 5: register index width.
- MULDIV_LAT, 4: cycles a MUL/DIV occupies EX. Legal values are 2 or more; elaboration fails below 2.
- STALL_CNT_W, 16: width of the stall performance counter.

Ports:
- clk  in  1  pipeline clock
- rst_n  in  1  asynchronous active-low reset
- id_rs  in  NUM_RD_PORTS*REG_ADDR_W  ID-stage source registers; port k occupies bits [k*REG_ADDR_W +: REG_ADDR_W]
- id_rs_used  in  NUM_RD_PORTS  ID source k is actually read
- ex_rs  in  NUM_RD_PORTS*REG_ADDR_W  EX-stage source registers
- ex_rd  in  REG_ADDR_W  EX-stage destination
- ex_mem_read  in  1  EX instruction is a load
- ex_muldiv_start  in  1  EX instruction is MUL/DIV
- branch_taken_ex  in  1  branch or jump taken, resolved in EX
- regWrite_EXtoMEM  in  1  MEM-stage instruction writes the register file
- writeReg_EXtoMEM  in  REG_ADDR_W  MEM-stage destination
- regWrite_MEMtoWB  in  1  WB-stage instruction writes the register file
- writeReg_MEMtoWB  in  REG_ADDR_W  WB-stage destination
- forward_sel  out  2*NUM_RD_PORTS  per port: 00 regfile, 10 from EX/MEM, 01 from MEM/WB
- stall_if  out  1  hold PC
- stall_id  out  1  hold IF/ID register
- stall_ex  out  1  hold ID/EX register (MUL/DIV only)
- flush_id  out  1  zero IF/ID register
- flush_ex  out  1  insert bubble into ID/EX
- muldiv_done  out  1  one-cycle pulse when the MUL/DIV result is valid
- stall_count  out  STALL_CNT_W  saturating count of stall_if cycles

Behaviour:
Reset
- While rst_n is low: FSM goes to IDLE, countdown counter and stall_count are 0, and every output is 0, including forward_sel.

Forwarding (combinational, per port k)
- Select 10 when regWrite_EXtoMEM=1, writeReg_EXtoMEM!=0 and writeReg_EXtoMEM==ex_rs[k].
- Otherwise select 01 under the same condition using the MEM/WB signals.
- Otherwise select 00.
- EX/MEM always has priority over MEM/WB. Register x0 is never forwarded.

Load-use (combinational)
- Hazard when: ex_mem_read=1, ex_rd!=0, and for some k, id_rs_used[k]=1 and id_rs[k]==ex_rd.
- Response in that same cycle: stall_if=1, stall_id=1, flush_ex=1.
- Lasts exactly one cycle, because the bubble clears ex_mem_read on the next cycle.

Branch
- branch_taken_ex=1 in IDLE drives flush_id=1 and flush_ex=1 for that cycle.
- Branch wins over a simultaneous load-use: stall_if and stall_id are forced to 0.

MUL/DIV FSM
- States: IDLE, BUSY, DONE. A down-counter cnt is sized for MULDIV_LAT.
- IDLE with ex_muldiv_start=1:
  - Drive stall_if, stall_id and stall_ex to 1 in that cycle.
  - If MULDIV_LAT==2, the next state is DONE.
  - Otherwise the next state is BUSY with cnt=MULDIV_LAT-3.
- BUSY:
  - All three stalls are 1.
  - If cnt==0, go to DONE; otherwise decrement cnt.
  - branch_taken_ex and load-use detection are ignored.
- DONE:
  - muldiv_done=1 and no stalls.
  - ex_muldiv_start is ignored, since it is the same op leaving EX.
  - Next state is IDLE.
- Total stall cycles are MULDIV_LAT-1. muldiv_done asserts MULDIV_LAT-1 cycles after the start cycle.

Simultaneous events in IDLE
- ex_muldiv_start together with load-use cannot occur, because a load is not a MUL/DIV. If both are asserted, MUL/DIV wins.
- ex_muldiv_start together with branch_taken_ex: the branch wins and the FSM stays in IDLE.

stall_count
- Increments on each rising clk edge at which stall_if=1, saturating at all-ones.
- Reset mid-operation: an asynchronous reset in BUSY aborts immediately, with no muldiv_done pulse.

Decomposition:
- Package hazard_pkg holds:
  - the fwd_sel_e enum (FWD_REG=2'b00, FWD_WB=2'b01, FWD_MEM=2'b10);
  - the muldiv_state_e enum (IDLE, BUSY, DONE).
- Sub-module fwd_port_sel: one port's forwarding compare. Instantiate it NUM_RD_PORTS times in a generate loop.
- The FSM, load-use detection and counter stay in the top module.

Test Plan:
1. MEM/WB-only forwarding: regWrite_MEMtoWB=1, writeReg_MEMtoWB=5, ex_rs port0=5, port1=7 -> forward_sel port0=01, port1=00.
2. Double hazard: both write signals =1, both destinations =3, ex_rs port0=3 -> port0=10 (EX/MEM priority). Repeat with destinations =0 -> port0=00.
3. Load-use: ex_mem_read=1, ex_rd=9, id_rs port1=9, id_rs_used=2'b10 -> one cycle of stall_if=stall_id=flush_ex=1. Same stimulus with id_rs_used=2'b00 -> no stall.
4. MUL/DIV with MULDIV_LAT=4: start at cycle N -> stalls high at N, N+1, N+2; muldiv_done=1 at N+3; stall_count=3.
5. Branch with load-use: branch_taken_ex and the load-use condition in the same cycle -> flush_id=flush_ex=1, stall_if=0. Then assert rst_n=0 during BUSY -> all outputs 0 immediately, no muldiv_done.
6. Saturation: STALL_CNT_W=4 with 20 consecutive stall cycles -> stall_count holds at 15.
